// File: rtl/moore_pulse_driver.sv
// Pulse-train driver for the mod-4 Moore pulse counter: bursts of single-cycle pulses
// with a GAP-cycle spacing, plus a receiver-state mirror. Optional check: MOORE_PULSE_DRIVER_CHECK_EN.
module moore_pulse_driver #(
    parameter int CW  = 8,
    parameter int GAP = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] count_in,
    input  logic          abort,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          x_out,
    output logic [1:0]    mirror_state,
    output logic          y_expect,
    input  logic          y_in,
    output logic          mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]    GAP_LOAD = 4'(GAP);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    state_t        state_r, state_s;
    logic [CW-1:0] remaining_r, remaining_s;
    logic [3:0]    gap_cnt_r, gap_cnt_s;
    logic [1:0]    mirror_r, mirror_s;

    // State, counters and receiver mirror registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= CNT_ZERO;
            gap_cnt_r   <= 4'd0;
            mirror_r    <= 2'd0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            gap_cnt_r   <= gap_cnt_s;
            mirror_r    <= mirror_s;
        end
    end

    // Next-state logic; the mirror advances on every emitted pulse, including one cut short by abort.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        gap_cnt_s   = gap_cnt_r;
        mirror_s    = mirror_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (count_in != CNT_ZERO) begin
                        remaining_s = count_in;
                        state_s     = ST_PULSE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                remaining_s = remaining_r - CNT_ONE;
                mirror_s    = mirror_r + 2'd1;
                if ((remaining_r == CNT_ONE) || abort) begin
                    state_s = ST_DONE;
                end else if (GAP_LOAD == 4'd0) begin
                    state_s = ST_PULSE;
                end else begin
                    state_s   = ST_GAP;
                    gap_cnt_s = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else if (gap_cnt_r <= 4'd1) begin
                    state_s   = ST_PULSE;
                    gap_cnt_s = 4'd0;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign ready        = (state_r == ST_IDLE);
    assign busy         = (state_r == ST_PULSE) || (state_r == ST_GAP);
    assign done         = (state_r == ST_DONE);
    assign x_out        = (state_r == ST_PULSE);
    assign mirror_state = mirror_r;
    assign y_expect     = (mirror_r == 2'd3);

`ifdef MOORE_PULSE_DRIVER_CHECK_EN
    logic mismatch_r;

    // Sticky receiver-output compare; the receiver updates on the same edge as the mirror.
    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_r <= 1'b0;
        end else if (y_in != y_expect) begin
            mismatch_r <= 1'b1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign mismatch = mismatch_r;
`else
    logic unused_y_in;
    assign unused_y_in = y_in;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: doc/moore_pulse_driver.md
Name: moore_pulse_driver

Overview:
- Transmit-side partner for the mod-4 Moore pulse-counter FSM: generates the `x_in` pulse train that drives the counter.
- Emits a requested number of single-cycle pulses with a fixed inter-pulse gap, under a start/done handshake.
- Keeps a mirror of the receiver's 2-bit state and produces the expected receiver output, so benches and upper-level controllers can drive the counter to a known state.

Parameters:
- CW, 8: width of the pulse-count request and the internal remaining-pulse counter.
- GAP, 1: idle cycles between consecutive pulses. Legal range 0..15; 0 means back-to-back pulses.

Ports:
- clock  input  1  single clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a burst; sampled only in IDLE
- count_in  input  CW  number of pulses for the burst; latched when start is accepted
- abort  input  1  stop the burst early; effective in PULSE/GAP only
- ready  output  1  high in IDLE
- busy  output  1  high in PULSE or GAP
- done  output  1  single-cycle completion strobe
- x_out  output  1  pulse train, connects to the receiver's x_in
- mirror_state  output  2  modelled receiver state, 0..3
- y_expect  output  1  high when mirror_state == 3
- y_in  input  1  receiver y_out; used only with CHECK feature
- mismatch  output  1  sticky compare error; constant 0 without CHECK feature

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports named clock and reset).
- Reset values: state=IDLE, ready=1, busy=0, done=0, x_out=0, mirror_state=0, y_expect=0, mismatch=0. Remaining and gap counters are cleared.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- FSM states: IDLE, PULSE, GAP, DONE.
- IDLE:
  - start=1 and count_in!=0: latch remaining=count_in, go to PULSE.
  - start=1 and count_in==0: go to DONE; no pulses are emitted.
  - start=0: stay in IDLE.
- PULSE (exactly one cycle): x_out=1. At the end of the cycle, mirror_state increments mod 4 (3 wraps to 0) and remaining decrements. Next state:
  - remaining was 1, or abort=1: DONE.
  - GAP==0: PULSE.
  - otherwise: GAP, with gap counter loaded to GAP.
- GAP: x_out=0 for exactly GAP cycles, then PULSE. abort=1 in any GAP cycle goes to DONE next cycle.
- DONE: done=1 for one cycle, then IDLE.
- start asserted outside IDLE is ignored (not queued). count_in is a don't-care outside the accepting cycle.
- abort in IDLE or DONE has no effect. A pulse already on x_out in the abort cycle still counts.
- Latency:
  - First pulse appears the cycle after start is accepted.
  - A burst of N pulses occupies N + (N-1)*GAP cycles in PULSE/GAP, followed by one DONE cycle.
- mirror_state is not cleared between bursts; it tracks the receiver continuously. Only reset clears it, matching the receiver, which resets to S0 from the same reset event.
- reset asserted mid-burst:
  - next cycle: IDLE, x_out=0, mirror_state=0;
  - no done strobe is produced for the killed burst.
- Receiver timing: the receiver samples x_out on the same edge that updates mirror_state. Therefore y_in is valid, and equals y_expect, in the same cycle.

Optional Feature:
- Macro: MOORE_PULSE_DRIVER_CHECK_EN.
- Defined:
  - every cycle after reset deasserts, compare y_in against y_expect;
  - any difference sets mismatch=1 on the next edge;
  - mismatch is sticky until reset.
- Undefined:
  - y_in is ignored;
  - mismatch is tied to 0;
  - no compare logic is synthesized.

Test Plan:
1. Reset, GAP=1, start with count_in=3 at cycle 0.
   - x_out=1 in cycles 1, 3, 5; 0 otherwise.
   - done=1 in cycle 6; ready=1 in cycle 7.
   - mirror_state=3 and y_expect=1 from cycle 6.
2. From mirror_state=3, start with count_in=5 and GAP=0.
   - x_out high for 5 consecutive cycles; mirror_state sequence 0, 1, 2, 3, 0.
   - done 1 cycle after the last pulse; y_expect=0 at the end.
3. start with count_in=0.
   - x_out never high; done=1 the next cycle; mirror_state unchanged.
4. GAP=2, count_in=6, abort asserted during the GAP after the 2nd pulse.
   - Exactly 2 pulses emitted; done the next cycle; mirror_state advanced by 2.
   - start pulsed while busy during this burst is ignored.
5. Reset asserted during PULSE of a 4-pulse burst.
   - Next cycle: IDLE, x_out=0, mirror_state=0, no done.
   - A new start then behaves as in scenario 1.
6. With MOORE_PULSE_DRIVER_CHECK_EN defined, connect the real counter; then force y_in=0 while y_expect=1.
   - mismatch=1 the following cycle and stays 1 until reset.
   - With the real counter connected (no forcing), mismatch stays 0 across scenarios 1–4.
